bcd_digit_converter: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the multiplexed seven-segment display driver. It takes a binary result from the processor datapath, such as a writeback value or register-file readout. It converts it with iterative shift-add-3 (double dabble) and presents one 4-bit digit per display position, so the display stage no longer needs combinational divide/modulo logic. Values that do not fit in DIGITS decimal digits are flagged and presented as the all-ones blank code that the display already uses for out-of-range values.

---
 rtl/bcd_digit_converter_if.sv | 31 +++
 rtl/bcd_digit_converter.sv | 154 +++++++++++++++
 tb/tb_bcd_digit_converter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_converter_if
// Description : Request/result bundle between a binary producer and the
//               sequential binary-to-BCD converter feeding the display.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_digit_converter_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   digits;

  // Producer side: issues requests, observes results
  modport master (
    output start, value,
    input  busy, done, overflow, digits
  );

  // Converter side
  modport slave (
    input  start, value,
    output busy, done, overflow, digits
  );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_converter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_converter
// Description : Iterative shift-add-3 (double dabble) binary-to-BCD converter.
//               One input bit per cycle, MSB first. Values that do not fit in
//               DIGITS decimal digits are flagged and shown as all-ones blanks.
//               Optional macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero
//               digits (digit 0 always shown) on non-overflow results.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_converter #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  bcd_digit_converter_if.slave   bus
);

  localparam int                 ACC_W    = 4 * DIGITS;
  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               busy_q;
  logic               done_q;
  logic               overflow_q;
  logic [ACC_W-1:0]   digits_q;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   result;

  // Add 3 to every digit that is 5 or more, all digits from the pre-shift value
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath update for the conversion sequencer
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d = bus.value;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d   = {acc_adj[ACC_W-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        // A set top bit would be shifted out: value no longer fits
        if (acc_adj[ACC_W-1]) begin
          ovf_d = 1'b1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Final digit pattern presented when the conversion completes
`ifdef BCD_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    result  = ovf_q ? {ACC_W{1'b1}} : acc_q;
    if (!ovf_q) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (!seen_nz && (acc_q[4*i +: 4] == 4'd0)) begin
          result[4*i +: 4] = 4'hF;
        end else begin
          seen_nz = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    result = ovf_q ? {ACC_W{1'b1}} : acc_q;
  end
`endif

  // Sequencer and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Registered outputs; results only move while the sequencer sits in DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      busy_q <= (state_q == S_SHIFT);
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        digits_q   <= result;
        overflow_q <= ovf_q;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.digits   = digits_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_digit_converter
// Description : Self-checking bench for bcd_digit_converter. Two instances:
//               default (7-bit, 2 digits) and full display (32-bit, 8 digits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_converter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_digit_converter_if #(.WIDTH(7),  .DIGITS(2)) ifa ();
  bcd_digit_converter_if #(.WIDTH(32), .DIGITS(8)) ifb ();

  bcd_digit_converter #(.WIDTH(7), .DIGITS(2)) dut_a (
    .clk_i (clk), .rst_ni (rst_n), .bus (ifa.slave)
  );
  bcd_digit_converter #(.WIDTH(32), .DIGITS(8)) dut_b (
    .clk_i (clk), .rst_ni (rst_n), .bus (ifb.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } res_t;

  typedef struct {
    logic [6:0] value;
    logic [7:0] exp_digits;
    logic       exp_ovf;
  } vec_t;

  // Reference: decimal digits by division, blanking by scanning from the top
  function automatic res_t model(input longint unsigned v, input int nd);
    res_t r;
    longint unsigned lim = 1;
    longint unsigned t;
    bit seen;
    r.d = '0;
    r.o = 1'b0;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v >= lim) begin
      r.o = 1'b1;
      for (int i = 0; i < nd; i++) r.d[4*i +: 4] = 4'hF;
    end else begin
      t = v;
      for (int i = 0; i < nd; i++) begin
        r.d[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
`ifdef BCD_LEADING_ZERO_BLANK_EN
      seen = 1'b0;
      for (int i = nd - 1; i >= 1; i--) begin
        if (!seen && r.d[4*i +: 4] == 4'd0) r.d[4*i +: 4] = 4'hF;
        else seen = 1'b1;
      end
`else
      seen = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Starts one conversion on instance A (DUT idle, called 1 time unit after an edge)
  task automatic conv_a(input logic [6:0] v, output logic [7:0] d, output logic o,
                        output int lat, output int nbusy);
    ifa.start = 1'b1;
    ifa.value = v;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifa.value = 7'($urandom);
    lat = -1;
    nbusy = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (ifa.busy) nbusy++;
      if (ifa.done) begin
        lat = n;
        break;
      end
    end
    d = ifa.digits;
    o = ifa.overflow;
  endtask

  task automatic conv_b(input logic [31:0] v, output logic [31:0] d, output logic o,
                        output int lat, output int nbusy);
    ifb.start = 1'b1;
    ifb.value = v;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    ifb.value = $urandom;
    lat = -1;
    nbusy = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (ifb.busy) nbusy++;
      if (ifb.done) begin
        lat = n;
        break;
      end
    end
    d = ifb.digits;
    o = ifb.overflow;
  endtask

  task automatic run_a(input string tag, input logic [6:0] v, input logic [7:0] ed, input logic eo);
    logic [7:0] d; logic o; int lat; int nb;
    conv_a(v, d, o, lat, nb);
    check({tag, ".lat"},    64'(lat), 64'd8);
    check({tag, ".busy"},   64'(nb),  64'd7);
    check({tag, ".digits"}, 64'(d),   64'(ed));
    check({tag, ".ovf"},    64'(o),   64'(eo));
  endtask

  task automatic run_b(input string tag, input logic [31:0] v);
    logic [31:0] d; logic o; int lat; int nb; res_t r;
    r = model(longint'(v), 8);
    conv_b(v, d, o, lat, nb);
    check({tag, ".lat"},    64'(lat), 64'd33);
    check({tag, ".busy"},   64'(nb),  64'd32);
    check({tag, ".digits"}, 64'(d),   64'(r.d));
    check({tag, ".ovf"},    64'(o),   64'(r.o));
  endtask

  initial begin
    vec_t vecs[10];
    res_t r;
    int   ndone;
    int   t1, t2;
    logic [7:0] dcap;

    vecs[0] = '{7'd42,  8'h42, 1'b0};
    vecs[1] = '{7'd99,  8'h99, 1'b0};
    vecs[2] = '{7'd100, 8'hFF, 1'b1};
    vecs[3] = '{7'd127, 8'hFF, 1'b1};
    vecs[4] = '{7'd10,  8'h10, 1'b0};
    vecs[5] = '{7'd80,  8'h80, 1'b0};
`ifdef BCD_LEADING_ZERO_BLANK_EN
    vecs[6] = '{7'd0,   8'hF0, 1'b0};
    vecs[7] = '{7'd5,   8'hF5, 1'b0};
    vecs[8] = '{7'd9,   8'hF9, 1'b0};
`else
    vecs[6] = '{7'd0,   8'h00, 1'b0};
    vecs[7] = '{7'd5,   8'h05, 1'b0};
    vecs[8] = '{7'd9,   8'h09, 1'b0};
`endif
    vecs[9] = '{7'd101, 8'hFF, 1'b1};

    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.value = '0;
    ifb.start = 1'b0; ifb.value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",   64'(ifa.busy),     64'd0);
    check("rst.done",   64'(ifa.done),     64'd0);
    check("rst.ovf",    64'(ifa.overflow), 64'd0);
    check("rst.digits", 64'(ifa.digits),   64'd0);
    check("rstb.digits",64'(ifb.digits),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors on the default instance
    for (int i = 0; i < 10; i++) begin
      run_a($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_digits, vecs[i].exp_ovf);
    end

    // Start during SHIFT is ignored: one Done, first value only
    ifa.start = 1'b1; ifa.value = 7'd57;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ifa.start = 1'b1; ifa.value = 7'd3;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ndone = 0; dcap = '0;
    for (int n = 0; n < 25; n++) begin
      if (ifa.done) begin ndone++; dcap = ifa.digits; end
      @(posedge clk); #1;
    end
    check("ign.ndone",  64'(ndone), 64'd1);
    check("ign.digits", 64'(dcap),  64'h57);
    r = model(64'd3, 2);
    run_a("ign.after", 7'd3, r.d[7:0], r.o);

    // Reset in the middle of a conversion
    ifa.start = 1'b1; ifa.value = 7'd88;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.busy",   64'(ifa.busy),   64'd0);
    check("midrst.done",   64'(ifa.done),   64'd0);
    check("midrst.digits", 64'(ifa.digits), 64'd0);
    ndone = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (ifa.done) ndone++;
      @(posedge clk); #1;
    end
    check("midrst.nodone", 64'(ndone), 64'd0);
    r = model(64'd5, 2);
    run_a("midrst.after", 7'd5, r.d[7:0], r.o);

    // Start held high: back-to-back conversions WIDTH+2 apart
    ifa.start = 1'b1; ifa.value = 7'd21;
    t1 = -1; t2 = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (ifa.done) begin
        if (t1 < 0) t1 = n;
        else begin
          t2 = n;
          ifa.start = 1'b0;
          break;
        end
      end
    end
    ifa.start = 1'b0;
    check("held.spacing", 64'(t2 - t1), 64'd9);
    check("held.digits",  64'(ifa.digits), 64'h21);
    repeat (2) @(posedge clk);
    #1;

    // Full display width corner cases
    run_b("b.max",   32'd99999999);
    run_b("b.over",  32'd100000000);
    run_b("b.zero",  32'd0);
    run_b("b.1020",  32'd1020);
    run_b("b.allF",  32'hFFFFFFFF);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [6:0] v;
      v = 7'($urandom_range(0, 127));
      r = model(longint'(v), 2);
      run_a($sformatf("rnda%0d", i), v, r.d[7:0], r.o);
    end
    for (int i = 0; i < 15; i++) begin
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
      run_b($sformatf("rndb%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
